// File: rtl/booth_r4_serial_mac.sv
//-----------------------------------------------------------------------------
// booth_r4_serial_mac
//
// Iterative radix-4 Booth multiplier/accumulator. Operand A is recoded into
// Booth digits {-2,-1,0,+1,+2}; PP_PER_CYCLE shifted partial products of B are
// added into an internal accumulator each BUSY cycle. The result is returned
// on a valid/ready stream. With in_acc=1 the new product is added to the
// previous result (MAC); otherwise the accumulator starts from zero.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   in_valid     operand transaction valid
//   in_ready     block can accept a transaction (high only in IDLE)
//   in_a         multiplier, Booth-recoded       [A_WIDTH]
//   in_b         multiplicand                    [B_WIDTH]
//   in_signed    1: operands two's complement, 0: unsigned
//   in_acc       1: accumulate onto previous result, 0: fresh product
//   out_valid    out_product valid
//   out_ready    consumer accepts out_product
//   out_product  result modulo 2^(A_WIDTH+B_WIDTH)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_r4_serial_mac #(
    parameter int A_WIDTH      = 8,
    parameter int B_WIDTH      = 8,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [A_WIDTH-1:0]           in_a,
    input  logic [B_WIDTH-1:0]           in_b,
    input  logic                         in_signed,
    input  logic                         in_acc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0]   out_product
);

    localparam int NUM_PP  = A_WIDTH / 2 + 1;
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int ACC_W   = P_WIDTH + 2;
    // idx never exceeds C*PP_PER_CYCLE < NUM_PP + PP_PER_CYCLE
    localparam int IDX_W   = $clog2(NUM_PP + PP_PER_CYCLE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [A_WIDTH+1:0]   r_a_ext;
    logic [B_WIDTH:0]     r_b_ext;
    logic [ACC_W-1:0]     r_acc;
    logic [IDX_W-1:0]     r_idx;

    logic                 w_ext_a;
    logic                 w_ext_b;
    logic [A_WIDTH+2:0]   w_a_pad;
    logic [ACC_W-1:0]     w_b_se;
    logic [ACC_W-1:0]     w_b2;
    logic [ACC_W-1:0]     w_pp_sum;
    logic                 w_last;

    assign w_ext_a = in_signed & in_a[A_WIDTH-1];
    assign w_ext_b = in_signed & in_b[B_WIDTH-1];

    // a_ext[-1] = 0 appended so digit k uses bits [2k+2:2k] of the padded vector
    assign w_a_pad = {r_a_ext, 1'b0};
    assign w_b_se  = {{(ACC_W-B_WIDTH-1){r_b_ext[B_WIDTH]}}, r_b_ext};
    assign w_b2    = w_b_se << 1;

    assign w_last  = (32'(r_idx) + 32'(PP_PER_CYCLE)) >= 32'(NUM_PP);

    //-------------------------------------------------------------------------
    // Partial-product sum for the digits handled this cycle
    //-------------------------------------------------------------------------
    always_comb begin
        logic [A_WIDTH+2:0] v_shift;
        logic [2:0]         v_trip;
        logic [ACC_W-1:0]   v_mult;
        int unsigned        v_k;
        w_pp_sum = '0;
        v_shift  = '0;
        v_trip   = '0;
        v_mult   = '0;
        v_k      = 0;
        for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
            v_k     = 32'(r_idx) + j;
            v_shift = w_a_pad >> (2 * v_k);
            v_trip  = v_shift[2:0];
            case (v_trip)
                3'b001, 3'b010: v_mult = w_b_se;
                3'b011:         v_mult = w_b2;
                3'b100:         v_mult = -w_b2;
                3'b101, 3'b110: v_mult = -w_b_se;
                default:        v_mult = '0;
            endcase
            if (v_k < 32'(NUM_PP)) begin
                w_pp_sum = w_pp_sum + (v_mult << (2 * v_k));
            end
        end
    end

    //-------------------------------------------------------------------------
    // FSM
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // Datapath
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_ext <= '0;
            r_b_ext <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_ext <= {w_ext_a, w_ext_a, in_a};
                        r_b_ext <= {w_ext_b, in_b};
                        r_acc   <= in_acc ? r_acc : '0;
                        r_idx   <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= r_acc + w_pp_sum;
                    r_idx <= r_idx + IDX_W'(PP_PER_CYCLE);
                end
                default: ;
            endcase
        end
    end

    assign out_product = r_acc[P_WIDTH-1:0];

endmodule
